// File: rtl/alu_wb_stage_pkg.sv
// Shared types and constants for the ALU writeback stage: condition codes,
// writeback entry layout, flag register layout and reset values.
package alu_wb_stage_pkg;

  localparam int VALUE_W = 32;
  localparam int RD_W    = 5;
  localparam int COND_W  = 3;

  // Stored writeback payload: value, destination index, write enable.
  localparam int ENTRY_W = VALUE_W + RD_W + 1;

  typedef enum logic [COND_W-1:0] {
    COND_AL = 3'b000,  // always
    COND_Z  = 3'b001,  // zero set
    COND_NZ = 3'b010,  // zero clear
    COND_C  = 3'b011,  // carry set
    COND_NC = 3'b100,  // carry clear
    COND_N  = 3'b101,  // negative set
    COND_NN = 3'b110,  // negative clear
    COND_NV = 3'b111   // never
  } cond_e;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [RD_W-1:0]    rd;
    logic               we;
  } entry_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
  } flags_t;

  localparam entry_t              ENTRY_RST  = '0;
  localparam flags_t              FLAGS_RST  = '0;
  localparam logic [VALUE_W-1:0]  TARGET_RST = '0;

  // Branches and writes to r0 still travel through the stage, but must never
  // write the register file.
  function automatic entry_t make_entry(input logic [VALUE_W-1:0] value,
                                        input logic [RD_W-1:0]    rd,
                                        input logic               we,
                                        input logic               is_branch);
    entry_t e;
    e.value = value;
    e.rd    = rd;
    e.we    = we & ~is_branch & (rd != '0);
    return e;
  endfunction

endpackage

// File: rtl/alu_wb_stage_cond_eval.sv
// Combinational branch condition evaluator against the architectural flags.
module cond_eval
  import alu_wb_stage_pkg::*;
(
  input  flags_t            flags,
  input  logic [COND_W-1:0] cond,
  output logic              taken
);

  // Decode the condition code into a taken decision.
  always_comb begin
    // NOTE: default assigned first so every path drives taken and no latch is inferred.
    taken = 1'b0;
    case (cond_e'(cond))
      COND_AL: taken = 1'b1;
      COND_Z:  taken = flags.z;
      COND_NZ: taken = ~flags.z;
      COND_C:  taken = flags.c;
      COND_NC: taken = ~flags.c;
      COND_N:  taken = flags.n;
      COND_NN: taken = ~flags.n;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: two-entry in-order buffer (output register + skid
// register) toward the register file, flag register updated at acceptance,
// and one-cycle branch-taken pulse resolved against the pre-existing flags.
module alu_wb_stage
  import alu_wb_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VALUE_W-1:0]  alu_value,
  input  logic                alu_carry,
  input  logic                alu_zero,
  input  logic                alu_msb,
  input  logic [RD_W-1:0]     in_rd,
  input  logic                in_we,
  input  logic                in_setflags,
  input  logic                in_is_branch,
  input  logic [COND_W-1:0]   in_cond,
  input  logic [VALUE_W-1:0]  in_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VALUE_W-1:0]  wb_value,
  output logic [RD_W-1:0]     wb_rd,
  output logic                wb_we,
  output logic                flag_c,
  output logic                flag_z,
  output logic                flag_n,
  output logic                br_taken,
  output logic [VALUE_W-1:0]  br_target
);

  entry_t             out_q;
  entry_t             skid_q;
  entry_t             new_entry;
  logic               out_valid_q;
  logic               skid_valid_q;
  flags_t             flags_q;
  logic               br_taken_q;
  logic [VALUE_W-1:0] br_target_q;
  logic               cond_taken;
  logic               accept;
  logic               retire;

  // in_ready comes straight from the skid-full register, so it never depends
  // combinationally on out_ready.
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid_q & out_ready;
  assign new_entry = make_entry(alu_value, in_rd, in_we, in_is_branch);

  cond_eval u_cond_eval (
    .flags (flags_q),
    .cond  (in_cond),
    .taken (cond_taken)
  );

  // Output/skid registers: keep order, reload output on retire, spill to skid on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too, so no stale value or write enable
      // is visible on the writeback port after reset.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= ENTRY_RST;
      skid_q       <= ENTRY_RST;
    end else if (retire) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (skid_valid_q) begin
        // Skid full means in_ready is low, so no accept can coincide here.
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q <= new_entry;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q) begin
        out_q       <= new_entry;
        out_valid_q <= 1'b1;
      end else begin
        skid_q       <= new_entry;
        skid_valid_q <= 1'b1;
      end
    end
  end

  // Flag register: updated when a flag-setting instruction is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_RST;
    end else if (accept && in_setflags) begin
      flags_q <= '{c: alu_carry, z: alu_zero, n: alu_msb};
    end
  end

  // Branch resolution: one-cycle pulse after a taken branch is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q  <= 1'b0;
      br_target_q <= TARGET_RST;
    end else begin
      br_taken_q <= accept & in_is_branch & cond_taken;
      if (accept && in_is_branch && cond_taken) begin
        br_target_q <= in_target;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign wb_value  = out_q.value;
  assign wb_rd     = out_q.rd;
  assign wb_we     = out_q.we;
  assign flag_c    = flags_q.c;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: vector table plus hand sequences,
// with a scoreboard queue of expected writeback entries.
module tb_alu_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_value;
  logic        alu_carry;
  logic        alu_zero;
  logic        alu_msb;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        in_setflags;
  logic        in_is_branch;
  logic [2:0]  in_cond;
  logic [31:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] wb_value;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        flag_c;
  logic        flag_z;
  logic        flag_n;
  logic        br_taken;
  logic [31:0] br_target;

  alu_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_value    (alu_value),
    .alu_carry    (alu_carry),
    .alu_zero     (alu_zero),
    .alu_msb      (alu_msb),
    .in_rd        (in_rd),
    .in_we        (in_we),
    .in_setflags  (in_setflags),
    .in_is_branch (in_is_branch),
    .in_cond      (in_cond),
    .in_target    (in_target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .wb_value     (wb_value),
    .wb_rd        (wb_rd),
    .wb_we        (wb_we),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .br_taken     (br_taken),
    .br_target    (br_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rd;
    logic        we;
    logic        sf;
    logic        c;
    logic        z;
    logic        n;
    logic        br;
    logic [2:0]  cond;
    logic [31:0] target;
    logic        exp_we;
    logic        exp_taken;
  } vec_t;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  rd;
    logic        we;
  } sb_t;

  sb_t         sb_q[$];
  logic [2:0]  flags_m;      // expected {c, z, n}
  logic        pend_taken;
  logic [31:0] pend_target;
  int          n_checks;
  int          n_fail;
  vec_t        vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] value, input logic [4:0] rd, input logic we,
                              input logic sf, input logic c, input logic z, input logic n,
                              input logic br, input logic [2:0] cond, input logic [31:0] target,
                              input logic exp_we, input logic exp_taken);
    vec_t v;
    v.value = value; v.rd = rd; v.we = we; v.sf = sf;
    v.c = c; v.z = z; v.n = n; v.br = br; v.cond = cond; v.target = target;
    v.exp_we = exp_we; v.exp_taken = exp_taken;
    return v;
  endfunction

  // Inputs are final when this is called: retirement is decided at the next edge.
  task automatic cycle();
    sb_t e;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("retire_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("wb_value", wb_value, e.value);
        check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        check("wb_we", {31'd0, wb_we}, {31'd0, e.we});
      end
    end
    @(negedge clk);
    check("out_valid", {31'd0, out_valid}, {31'd0, (sb_q.size() != 0)});
    check("in_ready", {31'd0, in_ready}, {31'd0, (sb_q.size() < 2)});
    check("br_taken", {31'd0, br_taken}, {31'd0, pend_taken});
    if (pend_taken) check("br_target", br_target, pend_target);
    pend_taken = 1'b0;
    check("flags", {29'd0, flag_c, flag_z, flag_n}, {29'd0, flags_m});
  endtask

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input vec_t v);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; alu_value = v.value; in_rd = v.rd; in_we = v.we;
    in_setflags = v.sf; alu_carry = v.c; alu_zero = v.z; alu_msb = v.n;
    in_is_branch = v.br; in_cond = v.cond; in_target = v.target;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) begin
        sb_t e;
        e.value = v.value; e.rd = v.rd; e.we = v.exp_we;
        sb_q.push_back(e);
        pend_taken  = v.exp_taken;
        pend_target = v.target;
        if (v.sf) flags_m = {v.c, v.z, v.n};
        done = 1'b1;
      end
      cycle();
    end
    in_valid = 1'b0; in_setflags = 1'b0; in_is_branch = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    flags_m = 3'b000; pend_taken = 1'b0; pend_target = 32'd0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_value = '0; alu_carry = 1'b0; alu_zero = 1'b0; alu_msb = 1'b0;
    in_rd = '0; in_we = 1'b0; in_setflags = 1'b0; in_is_branch = 1'b0;
    in_cond = '0; in_target = '0;

    // Vector table: out_ready held high, entries back to back.
    vecs[0]  = mk(32'h0000_0001, 5'd1,  1, 0, 0, 0, 0, 0, 3'b000, 32'h0,   1, 0);
    vecs[1]  = mk(32'hDEAD_BEEF, 5'd0,  1, 0, 0, 0, 0, 0, 3'b000, 32'h0,   0, 0);
    vecs[2]  = mk(32'h0000_0007, 5'd31, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0,   0, 0);
    vecs[3]  = mk(32'h0000_0000, 5'd2,  1, 1, 0, 1, 0, 0, 3'b000, 32'h0,   1, 0);
    vecs[4]  = mk(32'h0000_0044, 5'd4,  1, 0, 0, 0, 0, 1, 3'b001, 32'h200, 0, 1);
    vecs[5]  = mk(32'h0000_0045, 5'd4,  1, 0, 0, 0, 0, 1, 3'b010, 32'h204, 0, 0);
    vecs[6]  = mk(32'h8000_0000, 5'd5,  1, 1, 1, 0, 1, 0, 3'b000, 32'h0,   1, 0);
    vecs[7]  = mk(32'h0000_0046, 5'd6,  0, 0, 0, 0, 0, 1, 3'b101, 32'h300, 0, 1);
    vecs[8]  = mk(32'h0000_0047, 5'd6,  0, 0, 0, 0, 0, 1, 3'b100, 32'h304, 0, 0);
    vecs[9]  = mk(32'h0000_0048, 5'd6,  0, 0, 0, 0, 0, 1, 3'b111, 32'h308, 0, 0);
    vecs[10] = mk(32'h0000_0049, 5'd6,  0, 0, 0, 0, 0, 1, 3'b000, 32'h30C, 0, 1);
    vecs[11] = mk(32'h0000_004A, 5'd7,  1, 1, 0, 0, 1, 1, 3'b011, 32'h310, 0, 1);
    vecs[12] = mk(32'h0000_004B, 5'd7,  1, 0, 0, 0, 0, 1, 3'b110, 32'h314, 0, 0);

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_br_taken", {31'd0, br_taken}, 32'd0);
    check("rst_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
    check("rst_wb_value", wb_value, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check("rst_br_target", br_target, 32'd0);
    rst_n = 1'b1;
    cycle();

    // Single entry, one-cycle latency, then empty.
    out_ready = 1'b1;
    send(mk(32'h0000_0005, 5'd3, 1, 0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 0));
    check("lat_wb_value", wb_value, 32'h5);
    check("lat_wb_rd", {27'd0, wb_rd}, 32'd3);
    check("lat_wb_we", {31'd0, wb_we}, 32'd1);
    cycle();

    // Backpressure: fill both entries, hold, then drain in order.
    out_ready = 1'b0;
    send(mk(32'h0000_0011, 5'd6, 1, 0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 0));
    send(mk(32'h0000_0022, 5'd7, 1, 0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 0));
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    cycle();
    check("stall_hold_value", wb_value, 32'h11);
    out_ready = 1'b1;
    cycle();
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    check("drain_second_value", wb_value, 32'h22);
    cycle();
    cycle();

    // Branch on flags set by an earlier instruction.
    send(mk(32'h0000_0000, 5'd8, 1, 1, 1, 1, 0, 0, 3'b000, 32'h0, 1, 0));
    send(mk(32'h0000_0001, 5'd9, 1, 0, 0, 0, 0, 1, 3'b001, 32'h0000_0100, 0, 1));
    check("br_pulse", {31'd0, br_taken}, 32'd1);
    check("br_pulse_target", br_target, 32'h100);
    cycle();
    check("br_pulse_end", {31'd0, br_taken}, 32'd0);
    send(mk(32'h0000_0002, 5'd9, 1, 0, 0, 0, 0, 1, 3'b010, 32'h0000_0100, 0, 0));
    cycle();

    // A flag-setting branch evaluates against the old flags.
    send(mk(32'h0000_0000, 5'd8, 1, 1, 0, 0, 0, 0, 3'b000, 32'h0, 1, 0));
    send(mk(32'h0000_0003, 5'd9, 1, 1, 0, 1, 0, 1, 3'b001, 32'h0000_0180, 0, 0));
    check("own_flags_z", {31'd0, flag_z}, 32'd1);
    cycle();

    // Table-driven vectors, one per cycle with simultaneous accept and retire.
    for (int i = 0; i < 13; i++) send(vecs[i]);
    cycle();
    cycle();

    // Reset in the middle of a full buffer.
    out_ready = 1'b0;
    send(mk(32'h0000_00AA, 5'd9,  1, 1, 1, 1, 1, 0, 3'b000, 32'h0, 1, 0));
    send(mk(32'h0000_00BB, 5'd10, 1, 0, 0, 0, 0, 0, 3'b000, 32'h0, 1, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_wb_we", {31'd0, wb_we}, 32'd0);
    sb_q.delete();
    flags_m = 3'b000;
    pend_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
